// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: PC block command and fetch FSM state.
package fetch_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2
    } pc_cmd_t;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, single-entry output buffer,
// drives the PC block (INC per accepted request, LOAD on redirect).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WIDTH:0]  pc,
    output pc_cmd_t         cmd,
    output logic [WIDTH:0]  load_pc,
    input  logic            redirect_valid,
    input  logic [WIDTH:0]  redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [WIDTH:0]  mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [IW-1:0]   mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [IW-1:0]   instr_data,
    output logic [WIDTH:0]  instr_pc
);

    fetch_state_t   state;
    logic           drop;
    logic [WIDTH:0] req_pc;
    logic           buf_free;
    logic           req_fire;

    assign mem_addr = pc;

    // Request issue and PC command; redirect suppresses any request in its cycle.
    always_comb begin
        buf_free      = !instr_valid || instr_ready;
        mem_req_valid = 1'b0;
        cmd           = CMD_NONE;
        load_pc       = '0;
        if (!rst) begin
            if (redirect_valid) begin
                cmd     = CMD_LOAD;
                load_pc = redirect_pc;
            end else if (state == S_REQ && buf_free) begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    cmd = CMD_INC;
                end
            end
        end
        req_fire = mem_req_valid && mem_req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            instr_valid <= 1'b0;
            drop        <= 1'b0;
            req_pc      <= '0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
            // A still-outstanding read must be swallowed when it finally returns.
            if (state == S_WAIT && !mem_rsp_valid) begin
                drop <= 1'b1;
            end else begin
                state <= S_REQ;
                drop  <= 1'b0;
            end
        end else begin
            if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            instr_valid <= 1'b1;
                            instr_data  <= mem_rsp_data;
                            instr_pc    <= req_pc;
                        end
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC block, memory and decode models around the DUT, with a
// per-cycle reference of what fetch must present plus an in-order instruction stream check.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned AW    = WIDTH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    pc_cmd_t       cmd;
    logic [AW-1:0] load_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rsp_valid;
    logic [IW-1:0] mem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;

    fetch_unit #(.WIDTH(WIDTH), .IW(IW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .cmd(cmd), .load_pc(load_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Environment / reference state
    bit            pend = 0;
    bit            pend_killed = 0;
    logic [AW-1:0] pend_addr = '0;
    int            pend_wait = 0;
    bit            mb_valid = 0;
    logic [AW-1:0] mb_pc = '0;
    logic [IW-1:0] mb_data = '0;
    logic [AW-1:0] exp_next = '0;
    int            lat_lo = 0;
    int            lat_hi = 0;
    logic [AW-1:0] acc_pc[$];
    logic [IW-1:0] acc_data[$];

    // Outputs observed in the most recent step, before its clock edge
    pc_cmd_t       obs_cmd;
    logic [AW-1:0] obs_load;
    logic          obs_mrv;
    logic [AW-1:0] obs_addr;
    logic          obs_ivalid;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a * 3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the reference, clock, update.
    task automatic step(input bit r, input bit rv, input logic [AW-1:0] rpc,
                        input bit mrdy, input bit irdy);
        bit            rsp;
        bit            exp_mrv;
        bit            fire;
        bit            take;
        pc_cmd_t       exp_cmd;
        pc_cmd_t       cmd_q;
        logic [AW-1:0] load_q;

        rsp = pend && (pend_wait == 0 || r);
        rst = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_req_ready  = mrdy;
        instr_ready    = irdy;
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? mem_word(pend_addr) : IW'($urandom);
        #1;

        exp_mrv = !r && !rv && !pend && (!mb_valid || irdy);
        fire    = exp_mrv && mrdy;
        exp_cmd = r ? CMD_NONE : rv ? CMD_LOAD : fire ? CMD_INC : CMD_NONE;
        take    = !r && !rv && mb_valid && irdy;

        check("mem_req_valid", 64'(mem_req_valid), 64'(exp_mrv));
        check("cmd", 64'(cmd), 64'(exp_cmd));
        if (r || rv) check("load_pc", 64'(load_pc), r ? 64'(0) : 64'(rpc));
        if (mem_req_valid) check("mem_addr", 64'(mem_addr), 64'(pc));
        if (!r) begin
            check("instr_valid", 64'(instr_valid), 64'(mb_valid));
            if (mb_valid) begin
                check("instr_pc", 64'(instr_pc), 64'(mb_pc));
                check("instr_data", 64'(instr_data), 64'(mb_data));
            end
        end

        obs_cmd = cmd; obs_load = load_pc; obs_mrv = mem_req_valid;
        obs_addr = mem_addr; obs_ivalid = instr_valid;
        cmd_q = cmd; load_q = load_pc;

        @(posedge clk);
        #1;
        cyc++;

        if (take) begin
            check("stream_pc", 64'(mb_pc), 64'(exp_next));
            acc_pc.push_back(mb_pc);
            acc_data.push_back(mb_data);
            exp_next = exp_next + 1'b1;
        end

        if (r) begin
            pend = 0; mb_valid = 0; exp_next = '0; pc = '0;
        end else begin
            if (take) mb_valid = 0;
            if (rsp) begin
                pend = 0;
                if (!pend_killed && !rv) begin
                    mb_valid = 1; mb_pc = pend_addr; mb_data = mem_word(pend_addr);
                end
            end else if (pend) begin
                pend_wait--;
                if (rv) pend_killed = 1;
            end
            if (fire) begin
                pend = 1; pend_killed = 0; pend_addr = pc;
                pend_wait = $urandom_range(lat_hi, lat_lo);
            end
            if (rv) begin
                mb_valid = 0; exp_next = rpc;
            end
            if (cmd_q == CMD_INC) pc = pc + 1'b1;
            else if (cmd_q == CMD_LOAD) pc = load_q;
        end
        @(negedge clk);
    endtask

    int base;

    initial begin
        logic [AW-1:0] rt;
        bit rv_r;
        bit r_r;
        pc = '0; rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        check("rst_cmd", 64'(obs_cmd), 64'(CMD_NONE));
        check("rst_mrv", 64'(obs_mrv), 64'd0);
        check("rst_ivalid", 64'(instr_valid), 64'd0);

        // Streaming with zero-latency memory: one instruction every two cycles
        step(0, 0, '0, 1, 1);
        check("first_req_valid", 64'(obs_mrv), 64'd1);
        check("first_req_addr", 64'(obs_addr), 64'd0);
        check("first_cmd_inc", 64'(obs_cmd), 64'(CMD_INC));
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 1);
        check("stream_count", 64'(acc_pc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_pc.size()) begin
                check("stream_lit_pc", 64'(acc_pc[i]), 64'(i));
                check("stream_lit_data", 64'(acc_data[i]), 64'(3 * i));
            end
        end
        check("pc_after_stream", 64'(pc), 64'd5);

        // Backpressure: decode stalls, nothing new requested, nothing lost
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 0);
        check("bp_held_valid", 64'(instr_valid), 64'd1);
        check("bp_held_pc", 64'(instr_pc), 64'd4);
        check("bp_pc_frozen", 64'(pc), 64'd5);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1);
        check("bp_count", 64'(acc_pc.size()), 64'd6);

        // Redirect while a read is outstanding
        lat_lo = 2; lat_hi = 2;
        step(0, 0, '0, 1, 1);
        check("redir_pending", 64'(pend), 64'd1);
        step(0, 1, AW'(33'h40), 1, 1);
        check("redir_cmd", 64'(obs_cmd), 64'(CMD_LOAD));
        check("redir_load_pc", 64'(obs_load), 64'h40);
        step(0, 0, '0, 1, 1);
        check("redir_cmd_once", 64'(obs_cmd), 64'(CMD_NONE));
        lat_lo = 0; lat_hi = 0;
        base = acc_pc.size();
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, 1);
        check("redir_target_seen", 64'(acc_pc.size() > base), 64'd1);
        if (acc_pc.size() > base) begin
            check("redir_target_pc", 64'(acc_pc[base]), 64'h40);
            check("redir_target_data", 64'(acc_data[base]), 64'hC0);
        end

        // Redirect in the same cycle as the response
        for (int i = 0; i < 10 && !(pend && pend_wait == 0); i++) step(0, 0, '0, 1, 1);
        check("rsp_due", 64'(pend && pend_wait == 0), 64'd1);
        step(0, 1, AW'(33'h80), 1, 0);
        check("rsp_redir_ivalid", 64'(instr_valid), 64'd0);
        // Redirect while the output buffer holds an instruction
        for (int i = 0; i < 10 && !mb_valid; i++) step(0, 0, '0, 1, 0);
        check("buf_full", 64'(instr_valid), 64'd1);
        step(0, 1, AW'(33'h100), 1, 0);
        check("buf_redir_ivalid", 64'(instr_valid), 64'd0);
        base = acc_pc.size();
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 1);
        check("buf_redir_seen", 64'(acc_pc.size() > base), 64'd1);
        if (acc_pc.size() > base) begin
            check("buf_redir_pc", 64'(acc_pc[base]), 64'h100);
            check("buf_redir_data", 64'(acc_data[base]), 64'h300);
        end

        // Reset while waiting on memory; the flushed response lands during reset
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 10 && !pend; i++) step(0, 0, '0, 1, 1);
        check("wait_before_rst", 64'(pend), 64'd1);
        step(1, 0, '0, 1, 1);
        lat_lo = 0; lat_hi = 0;
        step(0, 0, '0, 1, 1);
        check("post_rst_req", 64'(obs_mrv), 64'd1);
        check("post_rst_addr", 64'(obs_addr), 64'd0);
        base = acc_pc.size();
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1);
        if (acc_pc.size() > base) check("post_rst_first_pc", 64'(acc_pc[base]), 64'd0);
        else check("post_rst_first_seen", 64'd0, 64'd1);

        // Randomized traffic, including redirects near the top of the address space
        lat_lo = 0; lat_hi = 3;
        base = acc_pc.size();
        for (int i = 0; i < 3000; i++) begin
            r_r  = ($urandom_range(199, 0) == 0);
            rv_r = !r_r && ($urandom_range(15, 0) == 0);
            if ($urandom_range(3, 0) == 0) rt = '1 - AW'($urandom_range(3, 0));
            else rt = AW'({$urandom(), $urandom()});
            step(r_r, rv_r, rt, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0));
        end
        check("random_progress", 64'(acc_pc.size() - base > 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
